// File: rtl/div_issue_ctrl.sv
// EX-stage issue controller for the multi-cycle divider: drives the start/cancel handshake,
// stalls the pipeline while a divide runs and returns the selected quotient or remainder.
module div_issue_ctrl #(
  parameter int DATA_W        = 32,
  parameter int CANCEL_CYCLES = 2
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                req_valid,
  input  logic [1:0]          req_op,
  input  logic [DATA_W-1:0]   req_src1,
  input  logic [DATA_W-1:0]   req_src2,
  input  logic                flush,
  output logic                stall_req,
  output logic [DATA_W-1:0]   result_o,
  output logic                result_vld,
  output logic                div_start,
  output logic                div_cancel,
  output logic                div_signed,
  output logic [DATA_W-1:0]   div_op1,
  output logic [DATA_W-1:0]   div_op2,
  input  logic [2*DATA_W-1:0] div_result,
  input  logic                div_done
);

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    BUSY    = 2'd1,
    RELEASE = 2'd2,
    CANCEL  = 2'd3
  } state_e;

  localparam logic [1:0] CANCEL_LAST = 2'(CANCEL_CYCLES - 1);

  state_e              state_q, state_d;
  logic [1:0]          cnt_q, cnt_d;
  logic                sel_rem_q, sel_rem_d;
  logic                start_q, start_d;
  logic                cancel_q, cancel_d;
  logic                signed_q, signed_d;
  logic                vld_q, vld_d;
  logic [DATA_W-1:0]   op1_q, op1_d;
  logic [DATA_W-1:0]   op2_q, op2_d;
  logic [DATA_W-1:0]   res_q, res_d;
  logic                accept_s;

  // Stall must rise in the accept cycle itself, so it is decoded from state and request.
  assign accept_s  = (state_q == IDLE) & req_valid & ~flush & ~rst;
  assign stall_req = accept_s | (state_q == BUSY);

  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    sel_rem_d = sel_rem_q;
    start_d   = start_q;
    cancel_d  = cancel_q;
    signed_d  = signed_q;
    vld_d     = 1'b0;
    op1_d     = op1_q;
    op2_d     = op2_q;
    res_d     = res_q;
    case (state_q)
      IDLE: begin
        if (accept_s) begin
          op1_d     = req_src1;
          op2_d     = req_src2;
          signed_d  = ~req_op[1];
          sel_rem_d = req_op[0];
          start_d   = 1'b1;
          state_d   = BUSY;
        end else begin
          start_d   = 1'b0;
        end
      end
      BUSY: begin
        // A flush wins over a simultaneous done: the result belongs to a killed op.
        if (flush) begin
          start_d  = 1'b0;
          cancel_d = 1'b1;
          cnt_d    = CANCEL_LAST;
          state_d  = CANCEL;
        end else if (div_done) begin
          res_d   = sel_rem_q ? div_result[2*DATA_W-1:DATA_W] : div_result[DATA_W-1:0];
          vld_d   = 1'b1;
          start_d = 1'b0;
          state_d = RELEASE;
        end else begin
          start_d = 1'b1;
        end
      end
      RELEASE: begin
        state_d = IDLE;
      end
      CANCEL: begin
        if (cnt_q == 2'd0) begin
          cancel_d = 1'b0;
          state_d  = IDLE;
        end else begin
          cnt_d = cnt_q - 2'd1;
        end
      end
      default: begin
        start_d  = 1'b0;
        cancel_d = 1'b0;
        state_d  = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q   <= IDLE;
      cnt_q     <= 2'd0;
      sel_rem_q <= 1'b0;
      start_q   <= 1'b0;
      cancel_q  <= 1'b0;
      signed_q  <= 1'b0;
      vld_q     <= 1'b0;
      op1_q     <= '0;
      op2_q     <= '0;
      res_q     <= '0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      sel_rem_q <= sel_rem_d;
      start_q   <= start_d;
      cancel_q  <= cancel_d;
      signed_q  <= signed_d;
      vld_q     <= vld_d;
      op1_q     <= op1_d;
      op2_q     <= op2_d;
      res_q     <= res_d;
    end
  end

  assign result_o   = res_q;
  assign result_vld = vld_q;
  assign div_start  = start_q;
  assign div_cancel = cancel_q;
  assign div_signed = signed_q;
  assign div_op1    = op1_q;
  assign div_op2    = op2_q;

endmodule

// File: tb/tb_div_issue_ctrl.sv
// Self-checking bench for div_issue_ctrl with a behavioural multi-cycle divider model.
module tb_div_issue_ctrl;

  logic        clk = 1'b0;
  logic        rst;
  logic        req_valid;
  logic [1:0]  req_op;
  logic [31:0] req_src1, req_src2;
  logic        flush;
  logic        stall_req;
  logic [31:0] result_o;
  logic        result_vld;
  logic        div_start, div_cancel, div_signed;
  logic [31:0] div_op1, div_op2;
  logic [63:0] div_result;
  logic        div_done;

  int n_assert = 0;
  int n_fail   = 0;

  div_issue_ctrl #(.DATA_W(32), .CANCEL_CYCLES(2)) dut (
    .clk(clk), .rst(rst), .req_valid(req_valid), .req_op(req_op),
    .req_src1(req_src1), .req_src2(req_src2), .flush(flush),
    .stall_req(stall_req), .result_o(result_o), .result_vld(result_vld),
    .div_start(div_start), .div_cancel(div_cancel), .div_signed(div_signed),
    .div_op1(div_op1), .div_op2(div_op2), .div_result(div_result), .div_done(div_done)
  );

  always #5 clk = ~clk;

  // RISC-V M semantics: x/0 yields 0 here (divider contract), remainder takes dividend sign.
  function automatic logic [31:0] ref_div(input logic [1:0] op, input logic [31:0] a,
                                          input logic [31:0] b);
    longint sa, sb, q, r;
    if (b == 32'd0) return 32'd0;
    if (!op[1]) begin
      sa = longint'($signed(a));
      sb = longint'($signed(b));
    end else begin
      sa = longint'({32'd0, a});
      sb = longint'({32'd0, b});
    end
    q = sa / sb;
    r = sa % sb;
    return op[0] ? r[31:0] : q[31:0];
  endfunction

  // Divider model: starts from idle on start, done after a random latency, held while start high.
  logic mdl_busy;
  int   mdl_cnt;
  always @(posedge clk or posedge rst) begin
    if (rst) begin
      mdl_busy   <= 1'b0;
      mdl_cnt    <= 0;
      div_done   <= 1'b0;
      div_result <= 64'd0;
    end else if (div_cancel) begin
      mdl_busy <= 1'b0;
      div_done <= 1'b0;
    end else if (mdl_busy) begin
      if (mdl_cnt == 0) begin
        mdl_busy   <= 1'b0;
        div_done   <= 1'b1;
        div_result <= {ref_div({!div_signed, 1'b1}, div_op1, div_op2),
                       ref_div({!div_signed, 1'b0}, div_op1, div_op2)};
      end else begin
        mdl_cnt <= mdl_cnt - 1;
      end
    end else if (div_done) begin
      if (!div_start) div_done <= 1'b0;
    end else if (div_start) begin
      mdl_busy <= 1'b1;
      mdl_cnt  <= int'($urandom_range(28, 38));
    end
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic start_op(input logic [1:0] op, input logic [31:0] a, input logic [31:0] b);
    req_valid = 1'b1;
    req_op    = op;
    req_src1  = a;
    req_src2  = b;
    #1;
    chk("stall_accept", 32'(stall_req), 32'd1);
    tick();
    chk("start_busy", 32'(div_start), 32'd1);
    chk("op1", div_op1, a);
    chk("op2", div_op2, b);
    chk("signed", 32'(div_signed), 32'(!op[1]));
    chk("stall_busy0", 32'(stall_req), 32'd1);
  endtask

  task automatic wait_result(input logic [31:0] exp);
    int i = 0;
    while (result_vld !== 1'b1 && i < 100) begin
      chk("stall_busy", 32'(stall_req), 32'd1);
      tick();
      i++;
    end
    chk("result_timeout", 32'(i < 100), 32'd1);
    chk("result", result_o, exp);
    chk("stall_release", 32'(stall_req), 32'd0);
    chk("start_release", 32'(div_start), 32'd0);
  endtask

  task automatic post_release(input logic [31:0] exp);
    tick();
    chk("vld_pulse", 32'(result_vld), 32'd0);
    chk("result_hold", result_o, exp);
    chk("start_idle", 32'(div_start), 32'd0);
  endtask

  task automatic do_op(input logic [1:0] op, input logic [31:0] a, input logic [31:0] b,
                       input logic [31:0] exp);
    start_op(op, a, b);
    wait_result(exp);
    req_valid = 1'b0;
    post_release(exp);
  endtask

  // n > 0: flush in the n-th BUSY cycle; n == 0: flush in the cycle div_done is seen.
  task automatic flush_op(input logic [1:0] op, input logic [31:0] a, input logic [31:0] b,
                          input int n);
    start_op(op, a, b);
    if (n > 0) begin
      repeat (n - 1) tick();
    end else begin
      int i = 0;
      while (div_done !== 1'b1 && i < 100) begin
        tick();
        i++;
      end
      chk("done_timeout", 32'(i < 100), 32'd1);
    end
    flush = 1'b1;
    tick();
    flush     = 1'b0;
    req_valid = 1'b0;
    chk("cancel1", 32'(div_cancel), 32'd1);
    chk("cancel1_start", 32'(div_start), 32'd0);
    chk("cancel1_stall", 32'(stall_req), 32'd0);
    chk("cancel1_vld", 32'(result_vld), 32'd0);
    tick();
    chk("cancel2", 32'(div_cancel), 32'd1);
    chk("cancel2_vld", 32'(result_vld), 32'd0);
    tick();
    chk("cancel_end", 32'(div_cancel), 32'd0);
    chk("cancel_end_vld", 32'(result_vld), 32'd0);
    chk("cancel_end_start", 32'(div_start), 32'd0);
  endtask

  initial begin
    logic [1:0]  rop;
    logic [31:0] ra, rb;
    rst       = 1'b1;
    req_valid = 1'b0;
    req_op    = 2'd0;
    req_src1  = 32'd0;
    req_src2  = 32'd0;
    flush     = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    chk("rst_stall", 32'(stall_req), 32'd0);
    chk("rst_vld", 32'(result_vld), 32'd0);
    chk("rst_start", 32'(div_start), 32'd0);
    chk("rst_cancel", 32'(div_cancel), 32'd0);
    chk("rst_result", result_o, 32'd0);
    rst = 1'b0;
    tick();

    do_op(2'b00, 32'hFFFF_FFF9, 32'd2, 32'hFFFF_FFFD);
    do_op(2'b01, 32'hFFFF_FFF9, 32'd2, 32'hFFFF_FFFF);
    do_op(2'b10, 32'hFFFF_FFFF, 32'h10, 32'h0FFF_FFFF);
    do_op(2'b11, 32'hFFFF_FFFF, 32'h10, 32'h0000_000F);
    do_op(2'b00, 32'd1234, 32'd0, 32'd0);

    flush_op(2'b00, 32'd50, 32'd5, 10);
    do_op(2'b10, 32'd100, 32'd7, 32'd14);
    flush_op(2'b10, 32'd77, 32'd3, 0);
    do_op(2'b01, 32'd100, 32'd7, 32'd2);

    // Asynchronous reset in the middle of a divide
    start_op(2'b00, 32'd1000, 32'd9);
    repeat (5) tick();
    req_valid = 1'b0;
    rst = 1'b1;
    #1;
    chk("arst_stall", 32'(stall_req), 32'd0);
    chk("arst_result", result_o, 32'd0);
    chk("arst_start", 32'(div_start), 32'd0);
    chk("arst_signed", 32'(div_signed), 32'd0);
    chk("arst_op1", div_op1, 32'd0);
    chk("arst_op2", div_op2, 32'd0);
    tick();
    rst = 1'b0;
    tick();

    // Back-to-back: next request presented during the release cycle
    start_op(2'b00, 32'd9, 32'd3);
    wait_result(32'd3);
    req_op   = 2'b01;
    req_src1 = 32'd9;
    req_src2 = 32'd4;
    #1;
    chk("b2b_release_stall", 32'(stall_req), 32'd0);
    post_release(32'd3);
    start_op(2'b01, 32'd9, 32'd4);
    wait_result(32'd1);
    req_valid = 1'b0;
    post_release(32'd1);

    for (int k = 0; k < 6; k++) begin
      rop = 2'($urandom_range(0, 3));
      ra  = $urandom;
      if (k == 2)       rb = 32'd0;
      else if (k[0])    rb = $urandom;
      else              rb = 32'($urandom_range(1, 50));
      if (k == 4) begin
        rop = 2'b00;
        ra  = 32'h8000_0000;
        rb  = 32'hFFFF_FFFF;
      end
      do_op(rop, ra, rb, ref_div(rop, ra, rb));
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
